slp_train_seq: RTL and testbench

//  Sequential multi-neuron single-layer perceptron trainer/inferencer with internal weight storage.

---
 rtl/perceptron_pkg.sv | 39 +++
 rtl/slp_wupdate.sv | 37 +++
 rtl/slp_train_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_slp_train_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared perceptron types: number formats, trainer FSM states and the
// fixed-point helpers used by the sequencer and its weight-update datapath.
package perceptron;

    typedef enum logic [1:0] {INT, FXP, FLT, BIN} dtype_t;

    typedef struct packed {
        dtype_t dtype;
        logic   sgn;
        int     prec;
        int     frac;
    } dconf_t;

    typedef enum logic [2:0] {IDLE, MAC, ACT, UPD, DONE} slp_state_t;

    function automatic int acc_width(input int i_prec, input int w_prec, input int weight);
        return i_prec + w_prec + $clog2(weight);
    endfunction

    function automatic logic dtype_ok(input dtype_t dt);
        return (dt == INT) || (dt == FXP);
    endfunction

    // Widen a prec-bit field to 64 bits, sign- or zero-extending as the format says.
    function automatic logic signed [63:0] ext(input logic [63:0] v, input int prec, input logic sgn);
        logic [63:0] m;
        m = (64'd1 << prec) - 64'd1;
        if (sgn && v[prec-1]) return signed'(v | ~m);
        return signed'(v & m);
    endfunction

    // Floor (arithmetic right shift) when dropping fraction bits, left shift when adding.
    function automatic logic signed [63:0] align_frac(input logic signed [63:0] v,
                                                      input int from_frac, input int to_frac);
        if (from_frac > to_frac) return v >>> (from_frac - to_frac);
        return v <<< (to_frac - from_frac);
    endfunction

endpackage

// File: rtl/slp_wupdate.sv
// Combinational weight update: w +/- align(rate*x), clipped to the weight range.
module slp_wupdate import perceptron::*; #(
    parameter dconf_t I_CONF = '{INT, 1'b1, 8, 3},
    parameter dconf_t R_CONF = '{INT, 1'b0, 4, 4},
    parameter dconf_t W_CONF = '{INT, 1'b1, 16, 4}
) (
    input  logic [R_CONF.prec-1:0] rate,
    input  logic [I_CONF.prec-1:0] x,
    input  logic [W_CONF.prec-1:0] w,
    input  logic                   sub,
    output logic [W_CONF.prec-1:0] w_new,
    output logic                   sat
);
    localparam int WP = W_CONF.prec;
    localparam logic signed [63:0] W_MAX = W_CONF.sgn ? (64'sd1 <<< (WP - 1)) - 64'sd1
                                                      : (64'sd1 <<< WP) - 64'sd1;
    localparam logic signed [63:0] W_MIN = W_CONF.sgn ? -(64'sd1 <<< (WP - 1)) : 64'sd0;

    logic signed [63:0] d;
    logic signed [63:0] sum;

    always_comb begin
        d     = align_frac(ext(64'(rate), R_CONF.prec, R_CONF.sgn) * ext(64'(x), I_CONF.prec, I_CONF.sgn),
                           R_CONF.frac + I_CONF.frac, W_CONF.frac);
        sum   = sub ? ext(64'(w), WP, W_CONF.sgn) - d : ext(64'(w), WP, W_CONF.sgn) + d;
        sat   = 1'b0;
        w_new = WP'(sum);
        if (sum > W_MAX) begin
            w_new = WP'(W_MAX);
            sat   = 1'b1;
        end else if (sum < W_MIN) begin
            w_new = WP'(W_MIN);
            sat   = 1'b1;
        end
    end

endmodule

// File: rtl/slp_train_seq.sv
// Single-layer perceptron trainer/inferencer: one shared MAC walks the neurons
// serially, then optionally rewrites a misclassifying neuron's weights in place.
module slp_train_seq import perceptron::*; #(
    parameter int     IN     = 8,
    parameter int     OUT    = 4,
    parameter dconf_t I_CONF = '{INT, 1'b1, 8, 3},
    parameter dconf_t R_CONF = '{INT, 1'b0, 4, 4},
    parameter dconf_t W_CONF = '{INT, 1'b1, 16, 4},
    parameter dconf_t P_CONF = '{INT, 1'b1, 8, 3},
    localparam int WEIGHT = IN + 1,
    localparam int I_PREC = I_CONF.prec,
    localparam int R_PREC = R_CONF.prec,
    localparam int W_PREC = W_CONF.prec,
    localparam int P_PREC = P_CONF.prec,
    localparam int OW     = (OUT > 1) ? $clog2(OUT) : 1,
    localparam int IW     = $clog2(WEIGHT),
    localparam int EW     = $clog2(OUT + 1)
) (
    input  logic                    clk,
    input  logic                    reset_,
    input  logic                    mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN*I_PREC-1:0]    in,
    input  logic [OUT-1:0]          target,
    input  logic [R_PREC-1:0]       rate,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT*P_PREC-1:0]   infer,
    output logic [EW-1:0]           err_cnt,
    output logic                    sat,
    input  logic                    w_we,
    input  logic [OW-1:0]           w_oidx,
    input  logic [IW-1:0]           w_iidx,
    input  logic [W_PREC-1:0]       w_wdata,
    output logic [W_PREC-1:0]       w_rdata,
    output logic                    w_err
);
    localparam int ACC_W = acc_width(I_PREC, W_PREC, WEIGHT);
    localparam logic [P_PREC-1:0] P_ONE = P_PREC'(1 << P_CONF.frac);

    if (!dtype_ok(I_CONF.dtype) || !dtype_ok(R_CONF.dtype) ||
        !dtype_ok(W_CONF.dtype) || !dtype_ok(P_CONF.dtype)) begin : g_bad_dtype
        $error("slp_train_seq: only INT or FXP number formats are supported");
    end

    slp_state_t               state_q, state_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [OW-1:0]            n_q, n_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [IN*I_PREC-1:0]     x_q, x_d;
    logic [OUT-1:0]           t_q, t_d;
    logic [R_PREC-1:0]        rate_q, rate_d;
    logic                     mode_q, mode_d;
    logic                     sub_q, sub_d;
    logic [OUT*P_PREC-1:0]    infer_q, infer_d;
    logic [EW-1:0]            err_cnt_q, err_cnt_d;
    logic                     sat_q, sat_d;
    logic                     out_valid_q, out_valid_d;
    logic                     w_err_q, w_err_d;
    logic [W_PREC-1:0]        w_q [OUT][WEIGHT];
    logic [W_PREC-1:0]        w_d [OUT][WEIGHT];

    logic [I_PREC-1:0]        x_arr [WEIGHT];
    logic [I_PREC-1:0]        x_cur;
    logic [W_PREC-1:0]        w_cur, w_upd;
    logic                     upd_sat, y, adv;
    logic signed [ACC_W-1:0]  prod;

    // The bias term sits at the last weight index with a constant 1.0 input.
    for (genvar gi = 0; gi < IN; gi++) begin : g_x
        assign x_arr[gi] = x_q[gi*I_PREC +: I_PREC];
    end
    assign x_arr[IN] = I_PREC'(1 << I_CONF.frac);

    assign x_cur = x_arr[idx_q];
    assign w_cur = w_q[n_q][idx_q];
    assign prod  = ACC_W'(ext(64'(x_cur), I_PREC, I_CONF.sgn)) * ACC_W'(ext(64'(w_cur), W_PREC, W_CONF.sgn));
    assign y     = ~acc_q[ACC_W-1];

    slp_wupdate #(.I_CONF(I_CONF), .R_CONF(R_CONF), .W_CONF(W_CONF)) u_wupdate (
        .rate  (rate_q),
        .x     (x_cur),
        .w     (w_cur),
        .sub   (sub_q),
        .w_new (w_upd),
        .sat   (upd_sat)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        n_d         = n_q;
        acc_d       = acc_q;
        x_d         = x_q;
        t_d         = t_q;
        rate_d      = rate_q;
        mode_d      = mode_q;
        sub_d       = sub_q;
        infer_d     = infer_q;
        err_cnt_d   = err_cnt_q;
        sat_d       = sat_q;
        out_valid_d = out_valid_q;
        w_err_d     = 1'b0;
        w_d         = w_q;
        adv         = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d       = in;
                    t_d       = target;
                    rate_d    = rate;
                    mode_d    = mode;
                    acc_d     = '0;
                    err_cnt_d = '0;
                    sat_d     = 1'b0;
                    n_d       = '0;
                    idx_d     = '0;
                    state_d   = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + prod;
                if (idx_q == IW'(WEIGHT - 1)) begin
                    idx_d   = '0;
                    state_d = ACT;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ACT: begin
                infer_d[int'(n_q)*P_PREC +: P_PREC] = y ? P_ONE : '0;
                sub_d = y;
                if (y != t_q[n_q]) err_cnt_d = err_cnt_q + EW'(1);
                if (mode_q && (y != t_q[n_q])) state_d = UPD;
                else                           adv     = 1'b1;
            end
            UPD: begin
                w_d[n_q][idx_q] = w_upd;
                if (upd_sat) sat_d = 1'b1;
                if (idx_q == IW'(WEIGHT - 1)) adv   = 1'b1;
                else                          idx_d = idx_q + IW'(1);
            end
            DONE: begin
                // out_valid rises one cycle after entering DONE and drops on the handshake.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (adv) begin
            acc_d = '0;
            idx_d = '0;
            if (n_q == OW'(OUT - 1)) begin
                state_d = DONE;
            end else begin
                n_d     = n_q + OW'(1);
                state_d = MAC;
            end
        end

        if (w_we) begin
            if (state_q == IDLE) begin
                for (int o = 0; o < OUT; o++)
                    for (int i = 0; i < WEIGHT; i++)
                        if (w_oidx == OW'(o) && w_iidx == IW'(i)) w_d[o][i] = w_wdata;
            end else begin
                w_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            idx_q       <= '0;
            n_q         <= '0;
            acc_q       <= '0;
            x_q         <= '0;
            t_q         <= '0;
            rate_q      <= '0;
            mode_q      <= 1'b0;
            sub_q       <= 1'b0;
            infer_q     <= '0;
            err_cnt_q   <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            w_err_q     <= 1'b0;
            for (int o = 0; o < OUT; o++)
                for (int i = 0; i < WEIGHT; i++)
                    w_q[o][i] <= '0;
        end else begin
            idx_q       <= idx_d;
            n_q         <= n_d;
            acc_q       <= acc_d;
            x_q         <= x_d;
            t_q         <= t_d;
            rate_q      <= rate_d;
            mode_q      <= mode_d;
            sub_q       <= sub_d;
            infer_q     <= infer_d;
            err_cnt_q   <= err_cnt_d;
            sat_q       <= sat_d;
            out_valid_q <= out_valid_d;
            w_err_q     <= w_err_d;
            w_q         <= w_d;
        end
    end

    always_comb begin
        w_rdata = '0;
        for (int o = 0; o < OUT; o++)
            for (int i = 0; i < WEIGHT; i++)
                if (w_oidx == OW'(o) && w_iidx == IW'(i)) w_rdata = w_q[o][i];
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign infer     = infer_q;
    assign err_cnt   = err_cnt_q;
    assign sat       = sat_q;
    assign w_err     = w_err_q;

endmodule

// File: tb/tb_slp_train_seq.sv
// Directed bench: instance a (IN=2, OUT=1) for training/inference checks,
// instance b (IN=2, OUT=4) for output hold and write rejection in DONE.
module tb_slp_train_seq;
    logic clk = 1'b0;
    logic reset_ = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        a_mode = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
    logic [15:0] a_in = '0;
    logic        a_target = 0;
    logic [3:0]  a_rate = '0;
    logic [7:0]  a_infer;
    logic        a_err_cnt, a_sat, a_w_we = 0, a_w_err;
    logic        a_w_oidx = 0;
    logic [1:0]  a_w_iidx = '0;
    logic [15:0] a_w_wdata = '0, a_w_rdata;

    logic        b_mode = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
    logic [15:0] b_in = '0;
    logic [3:0]  b_target = '0;
    logic [3:0]  b_rate = '0;
    logic [31:0] b_infer;
    logic [2:0]  b_err_cnt;
    logic        b_sat, b_w_we = 0, b_w_err;
    logic [1:0]  b_w_oidx = '0;
    logic [1:0]  b_w_iidx = '0;
    logic [15:0] b_w_wdata = '0, b_w_rdata;

    slp_train_seq #(.IN(2), .OUT(1)) dut_a (
        .clk(clk), .reset_(reset_), .mode(a_mode), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in(a_in), .target(a_target), .rate(a_rate), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .infer(a_infer), .err_cnt(a_err_cnt), .sat(a_sat), .w_we(a_w_we), .w_oidx(a_w_oidx),
        .w_iidx(a_w_iidx), .w_wdata(a_w_wdata), .w_rdata(a_w_rdata), .w_err(a_w_err)
    );

    slp_train_seq #(.IN(2), .OUT(4)) dut_b (
        .clk(clk), .reset_(reset_), .mode(b_mode), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in(b_in), .target(b_target), .rate(b_rate), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .infer(b_infer), .err_cnt(b_err_cnt), .sat(b_sat), .w_we(b_w_we), .w_oidx(b_w_oidx),
        .w_iidx(b_w_iidx), .w_wdata(b_w_wdata), .w_rdata(b_w_rdata), .w_err(b_w_err)
    );

    task automatic a_write(input int i, input logic [15:0] d);
        @(negedge clk);
        a_w_we = 1'b1; a_w_oidx = 1'b0; a_w_iidx = i[1:0]; a_w_wdata = d;
        @(negedge clk);
        a_w_we = 1'b0;
    endtask

    task automatic a_peek(input int i, output logic [15:0] w);
        a_w_oidx = 1'b0; a_w_iidx = i[1:0];
        #1;
        w = a_w_rdata;
    endtask

    task automatic a_run(input logic [15:0] x, input logic t, input logic [3:0] r, input logic m,
                         output int lat);
        @(negedge clk);
        a_in = x; a_target = t; a_rate = r; a_mode = m; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        lat = 0;
        while (!a_out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (a_out_valid !== 1'b1) begin bad++; $display("FAIL a_run_timeout out_valid=%b want=1", a_out_valid); end
    endtask

    task automatic a_release();
        @(negedge clk);
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [15:0] w;
        repeat (3) @(negedge clk);
        total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", a_in_ready); end
        total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", a_out_valid); end
        total++; if (a_err_cnt !== 1'b0) begin bad++; $display("FAIL reset_err_cnt got=%b want=0", a_err_cnt); end
        total++; if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_b_handshake in_ready=%b out_valid=%b want=1/0", b_in_ready, b_out_valid); end
        for (int i = 0; i < 3; i++) begin
            a_peek(i, w);
            total++; if (w !== 16'h0000) begin bad++; $display("FAIL reset_weight[%0d] got=%h want=0000", i, w); end
        end
        @(negedge clk);
        reset_ = 1'b1;
        $display("reset: checked");
    endtask

    task automatic test_train();
        int lat;
        logic [15:0] w;
        a_run(16'h0808, 1'b0, 4'd8, 1'b1, lat);
        total++; if (lat !== 8) begin bad++; $display("FAIL train_latency got=%0d want=8", lat); end
        total++; if (a_infer !== 8'd8) begin bad++; $display("FAIL train_infer got=%0d want=8", a_infer); end
        total++; if (a_err_cnt !== 1'b1) begin bad++; $display("FAIL train_err_cnt got=%b want=1", a_err_cnt); end
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL train_in_ready got=%b want=0", a_in_ready); end
        total++; if (a_sat !== 1'b0) begin bad++; $display("FAIL train_sat got=%b want=0", a_sat); end
        a_release();
        for (int i = 0; i < 3; i++) begin
            a_peek(i, w);
            total++; if (w !== 16'hFFF8) begin bad++; $display("FAIL train_weight[%0d] got=%h want=fff8", i, w); end
        end
        $display("train: x=(1.0,1.0) t=0 lat=%0d infer=%0d", lat, a_infer);
    endtask

    task automatic test_infer();
        int lat;
        logic [15:0] w;
        a_run(16'h0808, 1'b0, 4'd8, 1'b0, lat);
        total++; if (lat !== 5) begin bad++; $display("FAIL infer_neg_latency got=%0d want=5", lat); end
        total++; if (a_infer !== 8'd0) begin bad++; $display("FAIL infer_neg_infer got=%0d want=0", a_infer); end
        total++; if (a_err_cnt !== 1'b0) begin bad++; $display("FAIL infer_neg_err_cnt got=%b want=0", a_err_cnt); end
        a_release();
        for (int i = 0; i < 3; i++) a_write(i, 16'h0000);
        a_run(16'h0808, 1'b0, 4'd8, 1'b0, lat);
        total++; if (lat !== 5) begin bad++; $display("FAIL infer_latency got=%0d want=5", lat); end
        total++; if (a_infer !== 8'd8) begin bad++; $display("FAIL infer_infer got=%0d want=8", a_infer); end
        total++; if (a_err_cnt !== 1'b1) begin bad++; $display("FAIL infer_err_cnt got=%b want=1", a_err_cnt); end
        a_release();
        for (int i = 0; i < 3; i++) begin
            a_peek(i, w);
            total++; if (w !== 16'h0000) begin bad++; $display("FAIL infer_weight[%0d] got=%h want=0000", i, w); end
        end
        $display("infer: mode=0 lat=%0d infer=%0d", lat, a_infer);
    endtask

    task automatic test_sat();
        int lat;
        logic [15:0] w;
        logic [15:0] exp_w [3];
        exp_w = '{16'h7FFF, 16'h80EE, 16'h000E};
        a_write(0, 16'h7FFF);
        a_write(1, 16'h8000);
        a_write(2, 16'hFFFF);
        a_run(16'h7F7F, 1'b1, 4'd15, 1'b1, lat);
        total++; if (lat !== 8) begin bad++; $display("FAIL sat_latency got=%0d want=8", lat); end
        total++; if (a_infer !== 8'd0) begin bad++; $display("FAIL sat_infer got=%0d want=0", a_infer); end
        total++; if (a_sat !== 1'b1) begin bad++; $display("FAIL sat_flag got=%b want=1", a_sat); end
        a_release();
        for (int i = 0; i < 3; i++) begin
            a_peek(i, w);
            total++; if (w !== exp_w[i]) begin bad++; $display("FAIL sat_weight[%0d] got=%h want=%h", i, w, exp_w[i]); end
        end
        $display("sat: w0 clipped at max, sat=%b", a_sat);
    endtask

    task automatic test_floor();
        int lat;
        logic [15:0] w;
        logic [15:0] exp_w [3];
        exp_w = '{16'h8002, 16'hFF12, 16'hFFF1};
        a_write(0, 16'h8000);
        a_write(1, 16'h0000);
        a_write(2, 16'h0000);
        a_run(16'h7FFF, 1'b0, 4'd15, 1'b1, lat);
        total++; if (a_infer !== 8'd8) begin bad++; $display("FAIL floor_infer got=%0d want=8", a_infer); end
        total++; if (a_sat !== 1'b0) begin bad++; $display("FAIL floor_sat got=%b want=0", a_sat); end
        a_release();
        for (int i = 0; i < 3; i++) begin
            a_peek(i, w);
            total++; if (w !== exp_w[i]) begin bad++; $display("FAIL floor_weight[%0d] got=%h want=%h", i, w, exp_w[i]); end
        end
        $display("floor: negative x, subtract update, lat=%0d", lat);
    endtask

    task automatic test_hold();
        int lat;
        @(negedge clk);
        b_in = 16'h0808; b_target = 4'b0101; b_rate = 4'd8; b_mode = 1'b1; b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        total++; if (lat !== 23) begin bad++; $display("FAIL hold_latency got=%0d want=23", lat); end
        for (int c = 0; c < 10; c++) begin
            total++; if (b_out_valid !== 1'b1 || b_in_ready !== 1'b0) begin
                bad++; $display("FAIL hold_handshake cyc=%0d out_valid=%b in_ready=%b want=1/0", c, b_out_valid, b_in_ready); end
            total++; if (b_infer !== 32'h08080808 || b_err_cnt !== 3'd2) begin
                bad++; $display("FAIL hold_outputs cyc=%0d infer=%h err_cnt=%0d want=08080808/2", c, b_infer, b_err_cnt); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        b_w_we = 1'b1; b_w_oidx = 2'd1; b_w_iidx = 2'd0; b_w_wdata = 16'h1234;
        @(posedge clk); #1;
        total++; if (b_w_err !== 1'b1) begin bad++; $display("FAIL hold_w_err got=%b want=1", b_w_err); end
        @(negedge clk);
        b_w_we = 1'b0;
        @(posedge clk); #1;
        total++; if (b_w_err !== 1'b0) begin bad++; $display("FAIL hold_w_err_pulse got=%b want=0", b_w_err); end
        total++; if (b_w_rdata !== 16'hFFF8) begin bad++; $display("FAIL hold_weight_1_0 got=%h want=fff8", b_w_rdata); end
        b_w_oidx = 2'd0; #1;
        total++; if (b_w_rdata !== 16'h0000) begin bad++; $display("FAIL hold_weight_0_0 got=%h want=0000", b_w_rdata); end
        b_w_oidx = 2'd3; b_w_iidx = 2'd2; #1;
        total++; if (b_w_rdata !== 16'hFFF8) begin bad++; $display("FAIL hold_weight_3_2 got=%h want=fff8", b_w_rdata); end
        @(negedge clk);
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        total++; if (b_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
            bad++; $display("FAIL hold_release in_ready=%b out_valid=%b want=1/0", b_in_ready, b_out_valid); end
        $display("hold: OUT=4 lat=%0d infer=%h err_cnt=%0d", lat, b_infer, b_err_cnt);
    endtask

    task automatic test_reset_mid();
        logic [15:0] w;
        @(negedge clk);
        a_in = 16'h0808; a_target = 1'b1; a_rate = 4'd8; a_mode = 1'b1; a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL mid_busy in_ready=%b want=0", a_in_ready); end
        #1;
        reset_ = 1'b0;
        #1;
        total++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            bad++; $display("FAIL mid_reset_handshake in_ready=%b out_valid=%b want=1/0", a_in_ready, a_out_valid); end
        for (int i = 0; i < 3; i++) begin
            a_peek(i, w);
            total++; if (w !== 16'h0000) begin bad++; $display("FAIL mid_reset_weight[%0d] got=%h want=0000", i, w); end
        end
        @(negedge clk);
        reset_ = 1'b1;
        $display("reset_mid: reset during update cleared state");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_train();
        test_infer();
        test_sat();
        test_floor();
        test_hold();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
